// File: rtl/cpu_fifo_pkg.sv
// Shared definitions for the CPU/FIFO datapath stream blocks:
// demux FSM state encoding, default widths and the target-port helper.
package cpu_fifo_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT0 = 2'd1,
    PKT1 = 2'd2
  } demux_state_t;

  // Port a word goes to: chosen by sel at packet start, locked while a packet is open.
  function automatic logic target_port(input demux_state_t state, input logic sel);
    logic port;
    case (state)
      IDLE:    port = sel;
      PKT0:    port = 1'b0;
      PKT1:    port = 1'b1;
      default: port = 1'b0;
    endcase
    return port;
  endfunction

endpackage

// File: rtl/out_stage_reg.sv
// One-entry output register stage: holds a single word with its valid bit.
// It may load whenever it is empty or its word drains in the same cycle.
module out_stage_reg #(
  parameter int W = 73
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_payload,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_payload,
  output logic         o_can_load
);

  logic         r_valid;
  logic [W-1:0] r_payload;

  // Load wins over drain so a simultaneous load+drain keeps the stage full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_payload <= i_payload;
    end else if (i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_payload  = r_payload;
  assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/stream_demux_1_2.sv
// Registered 1-to-2 packet demultiplexer. Whole packets are steered to port 0
// or 1 by in_sel on the first word; the route holds until in_last.
// Optional packet counters are built when DEMUX_STATS_EN is defined.
//
// Handshake: on every port a word moves on a rising edge where valid && ready
// are both high; valid never depends on ready, and a presented word (data,
// ctrl, last) stays unchanged while valid && !ready.
module stream_demux_1_2
  import cpu_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_last,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [CTRL_W-1:0] out0_ctrl,
  output logic              out0_last,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CTRL_W-1:0] out1_ctrl,
  output logic              out1_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [1:0]        o_dbg_state
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

  localparam int PW = DATA_W + CTRL_W + 1;

  demux_state_t r_state;
  demux_state_t w_next_state;
  logic         w_target;
  logic         w_accept;
  logic         w_load0;
  logic         w_load1;
  logic         w_can_load0;
  logic         w_can_load1;
  logic [PW-1:0] w_in_payload;
  logic [PW-1:0] w_out0_payload;
  logic [PW-1:0] w_out1_payload;

  assign w_in_payload = {in_data, in_ctrl, in_last};

  // State register: a reset drops any partially routed packet.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next state: open a packet on a non-last first word, close it on its last word.
  always_comb begin
    w_next_state = r_state;
    if (w_accept) begin
      case (r_state)
        IDLE:       if (!in_last) w_next_state = in_sel ? PKT1 : PKT0;
        PKT0, PKT1: if (in_last)  w_next_state = IDLE;
        default:    w_next_state = IDLE;
      endcase
    end
  end

  // Outputs of the FSM: target port, in_ready from the target stage only, stage loads.
  always_comb begin
    w_target    = target_port(r_state, in_sel);
    in_ready    = rst_n && (w_target ? w_can_load1 : w_can_load0);
    w_accept    = in_valid && in_ready;
    w_load0     = w_accept && !w_target;
    w_load1     = w_accept &&  w_target;
    o_dbg_state = r_state;
  end

  out_stage_reg #(.W(PW)) u_stage0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load0),
    .i_payload  (w_in_payload),
    .i_ready    (out0_ready),
    .o_valid    (out0_valid),
    .o_payload  (w_out0_payload),
    .o_can_load (w_can_load0)
  );

  out_stage_reg #(.W(PW)) u_stage1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load1),
    .i_payload  (w_in_payload),
    .i_ready    (out1_ready),
    .o_valid    (out1_valid),
    .o_payload  (w_out1_payload),
    .o_can_load (w_can_load1)
  );

  assign {out0_data, out0_ctrl, out0_last} = w_out0_payload;
  assign {out1_data, out1_ctrl, out1_last} = w_out1_payload;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_pkt_cnt0;
  logic [CNT_W-1:0] r_pkt_cnt1;

  // Count packets as their last word leaves each port; wraps freely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pkt_cnt0 <= '0;
      r_pkt_cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready && out0_last) r_pkt_cnt0 <= r_pkt_cnt0 + 1'b1;
      if (out1_valid && out1_ready && out1_last) r_pkt_cnt1 <= r_pkt_cnt1 + 1'b1;
    end
  end

  assign pkt_cnt0 = r_pkt_cnt0;
  assign pkt_cnt1 = r_pkt_cnt1;
`else
  // Counter width has no consumer in this build.
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Bench for stream_demux_1_2: table of single-word packets, directed multi-cycle
// sequences, and a scoreboard fed at input acceptance and drained at output handoff.
module tb_stream_demux_1_2;
  import cpu_fifo_pkg::*;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int PW = DW + CW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_last, in_sel, in_valid, in_ready;
  logic [DW-1:0] out0_data, out1_data;
  logic [CW-1:0] out0_ctrl, out1_ctrl;
  logic          out0_last, out1_last, out0_valid, out1_valid;
  logic          out0_ready, out1_ready;
  logic [1:0]    dbg_state;
`ifdef DEMUX_STATS_EN
  logic [NW-1:0] pkt_cnt0, pkt_cnt1;
`endif

  stream_demux_1_2 #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_last(in_last), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_ctrl(out0_ctrl), .out0_last(out0_last),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_ctrl(out1_ctrl), .out1_last(out1_last),
    .out1_valid(out1_valid), .out1_ready(out1_ready),
    .o_dbg_state(dbg_state)
`ifdef DEMUX_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
  );

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];
  logic          m_in_pkt = 1'b0;
  logic          m_port   = 1'b0;
  logic          hold0 = 1'b0, hold1 = 1'b0;
  logic [PW-1:0] prev0, prev1;

  // Sampled on the falling edge: everything seen here takes effect at the next rising edge.
  always @(negedge clk) begin
    logic          tgt;
    logic          exp_rdy;
    logic [PW-1:0] cur0, cur1;
    cur0 = {out0_data, out0_ctrl, out0_last};
    cur1 = {out1_data, out1_ctrl, out1_last};
    if (!rst_n) begin
      chk("in_ready_in_reset", in_ready, 0);
      exp_q0.delete();
      exp_q1.delete();
      m_in_pkt = 1'b0;
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if (out0_valid && out0_ready) begin
        if (exp_q0.size() == 0) chk("port0_unexpected_word", cur0, 0 - 1);
        else chk("port0_word", cur0, exp_q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (exp_q1.size() == 0) chk("port1_unexpected_word", cur1, 0 - 1);
        else chk("port1_word", cur1, exp_q1.pop_front());
      end
      if (hold0) chk("port0_hold_stable", {out0_valid, cur0}, {1'b1, prev0});
      if (hold1) chk("port1_hold_stable", {out1_valid, cur1}, {1'b1, prev1});
      hold0 = out0_valid && !out0_ready;
      hold1 = out1_valid && !out1_ready;
      prev0 = cur0;
      prev1 = cur1;
      tgt     = m_in_pkt ? m_port : in_sel;
      exp_rdy = tgt ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
      chk("in_ready_model", in_ready, exp_rdy);
      if (in_valid && in_ready) begin
        if (tgt) exp_q1.push_back({in_data, in_ctrl, in_last});
        else     exp_q0.push_back({in_data, in_ctrl, in_last});
        if (!m_in_pkt && !in_last) begin
          m_in_pkt = 1'b1;
          m_port   = in_sel;
        end else if (m_in_pkt && in_last) begin
          m_in_pkt = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic l,
                       input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_sel   = s;
    in_last  = l;
    in_data  = d;
    in_ctrl  = c;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          sel;
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic          exp_port;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_cnt0, exp_cnt1;
    tbl[0] = '{1'b1, 64'hA5,                  8'h03, 1'b1};
    tbl[1] = '{1'b0, 64'hDEAD_BEEF_0123_4567, 8'h5A, 1'b0};
    tbl[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1};
    tbl[3] = '{1'b0, 64'h0,                   8'hFF, 1'b0};
    tbl[4] = '{1'b1, 64'h8000_0000_0000_0001, 8'h81, 1'b1};
    tbl[5] = '{1'b0, {$urandom, $urandom},    8'($urandom_range(0, 255)), 1'b0};

    rst_n = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid0", out0_valid, 0);
    chk("rst_valid1", out1_valid, 0);
    chk("rst_payload0", {out0_data, out0_ctrl, out0_last}, 0);
    chk("rst_payload1", {out1_data, out1_ctrl, out1_last}, 0);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_in_ready", in_ready, 0);
`ifdef DEMUX_STATS_EN
    chk("rst_cnt0", pkt_cnt0, 0);
    chk("rst_cnt1", pkt_cnt1, 0);
`endif
    tick();
    rst_n = 1'b1;

    // Single-word packets: routed by in_sel, visible one cycle after acceptance.
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, tbl[i].sel, 1'b1, tbl[i].data, tbl[i].ctrl);
      @(negedge clk);
      chk("tbl_in_ready", in_ready, 1);
      tick();
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      if (tbl[i].exp_port) begin
        chk("tbl_valid1", {out1_valid, out0_valid}, 2'b10);
        chk("tbl_data1", {out1_data, out1_ctrl, out1_last}, {tbl[i].data, tbl[i].ctrl, 1'b1});
        exp_cnt1++;
      end else begin
        chk("tbl_valid0", {out1_valid, out0_valid}, 2'b01);
        chk("tbl_data0", {out0_data, out0_ctrl, out0_last}, {tbl[i].data, tbl[i].ctrl, 1'b1});
        exp_cnt0++;
      end
      chk("tbl_state", dbg_state, IDLE);
      tick();
    end
    @(negedge clk);
`ifdef DEMUX_STATS_EN
    chk("tbl_cnt0", pkt_cnt0, exp_cnt0);
    chk("tbl_cnt1", pkt_cnt1, exp_cnt1);
`endif
    tick();

    // 4-word packet to port 0 while in_sel toggles every cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i % 2) == 1, i == 3, 64'h100 + 64'(i), 8'(i));
      @(negedge clk);
      chk("toggle_in_ready", in_ready, 1);
      if (i > 0) chk("toggle_port0_streaming", {out1_valid, out0_valid}, 2'b01);
      if (i > 0) chk("toggle_state", dbg_state, PKT0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("toggle_last_word", {out1_valid, out0_valid, out0_last}, 3'b011);
    chk("toggle_state_end", dbg_state, IDLE);
    tick();

    // Backpressure on port 0 for 3 cycles mid-packet.
    drive(1'b1, 1'b0, 1'b0, 64'h200, 8'h20);
    @(negedge clk);
    chk("bp_w0_ready", in_ready, 1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 64'h201, 8'h21);
    @(negedge clk);
    chk("bp_w1_ready", in_ready, 1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 64'h202, 8'h22);
    out0_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_data_held", out0_data, 64'h201);
      chk("bp_state", dbg_state, PKT0);
      tick();
    end
    out0_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_ready", in_ready, 1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 64'h203, 8'h23);
    @(negedge clk);
    chk("bp_w3_ready", in_ready, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    @(negedge clk);
    chk("bp_drained", {out1_valid, out0_valid}, 2'b00);
    chk("bp_q0_empty", exp_q0.size(), 0);
    tick();

    // Port 1 stalled holding one word while a port 0 packet streams.
    out1_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 64'h300, 8'h30);
    @(negedge clk);
    chk("ind_p1_ready", in_ready, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, i == 3, 64'h400 + 64'(i), 8'h40);
      @(negedge clk);
      chk("ind_in_ready", in_ready, 1);
      chk("ind_p1_held", {out1_valid, out1_data}, {1'b1, 64'h300});
      if (i > 0) chk("ind_p0_streaming", out0_valid, 1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    out1_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("ind_drained", {out1_valid, out0_valid}, 2'b00);
    chk("ind_q_empty", exp_q0.size() + exp_q1.size(), 0);
    tick();

    // Reset in the middle of a 5-word packet to port 0.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 64'h500 + 64'(i), 8'h50);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 64'h502, 8'h50);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    chk("mid_rst_valids", {out1_valid, out0_valid}, 2'b00);
    chk("mid_rst_state", dbg_state, IDLE);
    chk("mid_rst_payload0", {out0_data, out0_ctrl, out0_last}, 0);
`ifdef DEMUX_STATS_EN
    chk("mid_rst_cnt", {pkt_cnt1, pkt_cnt0}, 0);
`endif
    tick();
    drive(1'b1, 1'b1, 1'b1, 64'h5A5A, 8'h5A);
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("post_rst_route", {out1_valid, out0_valid}, 2'b10);
    chk("post_rst_data", out1_data, 64'h5A5A);
    tick();

`ifdef DEMUX_STATS_EN
    // Counter wrap: 17 single-word packets into a 4-bit counter.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 1'b1, 64'(i), 8'(i));
      @(negedge clk);
      chk("wrap_ready", in_ready, 1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    @(negedge clk);
    chk("wrap_cnt0", pkt_cnt0, 1);
    chk("wrap_cnt1", pkt_cnt1, 0);
    tick();
`endif

    // ---------------- final report ----------------
    repeat (3) tick();
    @(negedge clk);
    chk("final_q0_empty", exp_q0.size(), 0);
    chk("final_q1_empty", exp_q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
